// File: rtl/ahb_dual_manager_arbiter_if.sv
// AHB-lite link bundle: one manager<->subordinate connection.
// master drives HADDR..HWSTRB; slave returns HREADY/HRDATA/HRESP.
interface ahb_dual_manager_arbiter_if #(
  parameter int PA_BITS = 32,
  parameter int XLEN    = 32
);
  logic [PA_BITS-1:0] HADDR;
  logic               HWRITE;
  logic [1:0]         HTRANS;
  logic [2:0]         HSIZE;
  logic [XLEN-1:0]    HWDATA;
  logic [XLEN/8-1:0]  HWSTRB;
  logic               HREADY;
  logic [XLEN-1:0]    HRDATA;
  logic               HRESP;

  modport master (
    output HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HWSTRB,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    input  HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HWSTRB,
    output HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_dual_manager_arbiter.sv
// Two AHB managers (m0_if: LSU/IFU, m1_if: DMA/debug) share one
// subordinate port (sub_if); HCLK, HRESETn (async, active-low).
// Each address phase is held, arbitrated and replayed on sub_if.
// Macro AHB_ARB_ROUNDROBIN_EN: round-robin on contention,
// otherwise fixed priority by M0_PRIORITY (1: M0 wins).
module ahb_dual_manager_arbiter #(
  parameter int PA_BITS     = 32,
  parameter int XLEN        = 32,
  parameter bit M0_PRIORITY = 1'b1
) (
  input  logic HCLK,
  input  logic HRESETn,
  ahb_dual_manager_arbiter_if.slave  m0_if,
  ahb_dual_manager_arbiter_if.slave  m1_if,
  ahb_dual_manager_arbiter_if.master sub_if
);

  logic [1:0]         pend_q, iss_q;
  logic [PA_BITS-1:0] addr_q [2];
  logic [2:0]         size_q [2];
  logic [1:0]         wr_q;
  logic               dvld_q, down_q;

  logic [1:0] cand, own, rdy, cap, clr, gnt;
  logic       arb, win, acc, busy;
  logic       unused_ok;

  // HTRANS[0] only separates SEQ/NONSEQ and BUSY/IDLE; both are
  // irrelevant without burst support.
  assign unused_ok = ^{m0_if.HTRANS[0], m1_if.HTRANS[0]};

`ifdef AHB_ARB_ROUNDROBIN_EN
  logic last_q;
  // last_q=1 means M1 was granted last, so M0 is preferred next
  assign arb = ~last_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) last_q <= 1'b1;
    else if (acc) last_q <= win;
  end
`else
  assign arb = ~M0_PRIORITY;
`endif

  always_comb begin
    cand = pend_q & ~iss_q;
    busy = |cand;
    // arb picks M1 only when both are candidates
    win  = cand[1] & (~cand[0] | arb);
    acc  = busy & sub_if.HREADY;
    own  = {dvld_q & down_q, dvld_q & ~down_q};
    clr  = own & {2{sub_if.HREADY}};
    rdy  = ~pend_q | clr;
    cap  = {m1_if.HTRANS[1], m0_if.HTRANS[1]} & rdy;
    gnt  = acc ? (win ? 2'b10 : 2'b01) : 2'b00;
  end

  assign m0_if.HREADY = rdy[0];
  assign m1_if.HREADY = rdy[1];
  assign m0_if.HRDATA = sub_if.HRDATA;
  assign m1_if.HRDATA = sub_if.HRDATA;
  assign m0_if.HRESP  = own[0] & sub_if.HRESP;
  assign m1_if.HRESP  = own[1] & sub_if.HRESP;

  assign sub_if.HTRANS = busy ? 2'b10 : 2'b00;
  assign sub_if.HADDR  = busy ? addr_q[win] : '0;
  assign sub_if.HWRITE = busy & wr_q[win];
  assign sub_if.HSIZE  = busy ? size_q[win] : '0;

  assign sub_if.HWDATA = own[1] ? m1_if.HWDATA :
                         own[0] ? m0_if.HWDATA : '0;
  assign sub_if.HWSTRB = own[1] ? m1_if.HWSTRB :
                         own[0] ? m0_if.HWSTRB : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q    <= '0;
      iss_q     <= '0;
      addr_q[0] <= '0;
      addr_q[1] <= '0;
      size_q[0] <= '0;
      size_q[1] <= '0;
      wr_q      <= '0;
      dvld_q    <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      // a new capture overrides the completion of the old transfer
      for (int x = 0; x < 2; x++) begin
        if (cap[x]) begin
          pend_q[x] <= 1'b1;
          iss_q[x]  <= 1'b0;
        end else if (clr[x]) begin
          pend_q[x] <= 1'b0;
          iss_q[x]  <= 1'b0;
        end else if (gnt[x]) begin
          iss_q[x]  <= 1'b1;
        end
      end
      // holds load only when the manager is ready, so a driven
      // address phase stays stable through subordinate waits
      if (cap[0]) begin
        addr_q[0] <= m0_if.HADDR;
        size_q[0] <= m0_if.HSIZE;
        wr_q[0]   <= m0_if.HWRITE;
      end
      if (cap[1]) begin
        addr_q[1] <= m1_if.HADDR;
        size_q[1] <= m1_if.HSIZE;
        wr_q[1]   <= m1_if.HWRITE;
      end
      if (acc) begin
        dvld_q <= 1'b1;
        down_q <= win;
      end else if (sub_if.HREADY) begin
        dvld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_dual_manager_arbiter.sv
// Bench for ahb_dual_manager_arbiter: directed vector table,
// random traffic against a transaction-level model, reset corner.
module tb_ahb_dual_manager_arbiter;

  localparam bit M0P = 1'b1;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_dual_manager_arbiter_if #(.PA_BITS(32), .XLEN(32)) m0_if ();
  ahb_dual_manager_arbiter_if #(.PA_BITS(32), .XLEN(32)) m1_if ();
  ahb_dual_manager_arbiter_if #(.PA_BITS(32), .XLEN(32)) s_if ();

  ahb_dual_manager_arbiter #(
    .PA_BITS(32), .XLEN(32), .M0_PRIORITY(M0P)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_if(m0_if), .m1_if(m1_if), .sub_if(s_if)
  );

  logic [1:0]  t_i  [2];
  logic [31:0] a_i  [2];
  logic        w_i  [2];
  logic [2:0]  z_i  [2];
  logic [31:0] wd_i [2];
  logic [3:0]  sb_i [2];
  logic        s_rdy, s_rsp;
  logic [31:0] s_rd;

  assign m0_if.HTRANS = t_i[0];
  assign m0_if.HADDR  = a_i[0];
  assign m0_if.HWRITE = w_i[0];
  assign m0_if.HSIZE  = z_i[0];
  assign m0_if.HWDATA = wd_i[0];
  assign m0_if.HWSTRB = sb_i[0];
  assign m1_if.HTRANS = t_i[1];
  assign m1_if.HADDR  = a_i[1];
  assign m1_if.HWRITE = w_i[1];
  assign m1_if.HSIZE  = z_i[1];
  assign m1_if.HWDATA = wd_i[1];
  assign m1_if.HWSTRB = sb_i[1];
  assign s_if.HREADY  = s_rdy;
  assign s_if.HRDATA  = s_rd;
  assign s_if.HRESP   = s_rsp;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // ---- transaction-level reference model ----
  // a manager holds at most one outstanding request; owner is the
  // manager whose transfer is in the shared data phase (-1: none)
  bit          pend [2];
  bit          iss  [2];
  logic [31:0] h_ad [2];
  bit          h_wr [2];
  logic [2:0]  h_sz [2];
  int          owner;
  int          last;

  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      pend[x] = 0; iss[x] = 0;
    end
    owner = -1;
    last  = 1;
  endtask

  function automatic int pick();
    bit c0 = pend[0] && !iss[0];
    bit c1 = pend[1] && !iss[1];
    if (c0 && c1) begin
`ifdef AHB_ARB_ROUNDROBIN_EN
      return (last == 0) ? 1 : 0;
`else
      return M0P ? 0 : 1;
`endif
    end
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  function automatic bit m_rdy(int x);
    return !pend[x] || (owner == x && s_rdy);
  endfunction

  task automatic model_step();
    int w = pick();
    int o = owner;
    bit done = (owner >= 0) && s_rdy;
    bit cap [2];
    for (int x = 0; x < 2; x++) cap[x] = t_i[x][1] && m_rdy(x);
    if (done) begin
      pend[o] = 0; iss[o] = 0;
    end
    if (w >= 0 && s_rdy) begin
      iss[w] = 1; owner = w; last = w;
    end else if (done) begin
      owner = -1;
    end
    for (int x = 0; x < 2; x++) if (cap[x]) begin
      pend[x] = 1; iss[x] = 0;
      h_ad[x] = a_i[x]; h_wr[x] = w_i[x]; h_sz[x] = z_i[x];
    end
  endtask

  task automatic tick();
    if (!HRESETn) model_reset();
    else model_step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_all();
    int w = pick();
    chk("HTRANS", s_if.HTRANS, (w >= 0) ? 32'd2 : 32'd0);
    chk("HADDR",  s_if.HADDR,  (w >= 0) ? h_ad[w] : 32'd0);
    chk("HWRITE", s_if.HWRITE, (w >= 0) ? h_wr[w] : 1'b0);
    chk("HSIZE",  s_if.HSIZE,  (w >= 0) ? h_sz[w] : 3'd0);
    chk("HWDATA", s_if.HWDATA, (owner >= 0) ? wd_i[owner] : 32'd0);
    chk("HWSTRB", s_if.HWSTRB, (owner >= 0) ? sb_i[owner] : 4'd0);
    chk("HREADY0", m0_if.HREADY, m_rdy(0));
    chk("HREADY1", m1_if.HREADY, m_rdy(1));
    chk("HRDATA0", m0_if.HRDATA, s_rd);
    chk("HRDATA1", m1_if.HRDATA, s_rd);
    chk("HRESP0", m0_if.HRESP, (owner == 0) ? s_rsp : 1'b0);
    chk("HRESP1", m1_if.HRESP, (owner == 1) ? s_rsp : 1'b0);
  endtask

  task automatic idle_inputs();
    for (int x = 0; x < 2; x++) begin
      t_i[x] = 2'b00; a_i[x] = '0; w_i[x] = 1'b0;
      z_i[x] = 3'd2; wd_i[x] = '0; sb_i[x] = 4'hF;
    end
    s_rdy = 1'b1; s_rsp = 1'b0; s_rd = '0;
  endtask

  // ---- directed vector table ----
  typedef struct {
    logic [1:0] t0; logic [31:0] a0; logic w0; logic [31:0] wd0;
    logic [1:0] t1; logic [31:0] a1; logic w1; logic [31:0] wd1;
    logic rdy; logic [31:0] rd; logic rsp;
    logic [1:0] e_tr; logic [31:0] e_ad; logic e_wr; logic [31:0] e_wd;
    logic e_r0; logic e_r1; logic e_p0; logic e_p1; logic [31:0] e_rd0;
  } vec_t;

  vec_t tbl [16];

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants [$];
    int cnt [2];
    tbl[0]  = '{NS,32'h1000_0000,0,0, ID,0,0,0, 1,0,0, 0,0,0,0, 1,1,0,0,0};
    tbl[1]  = '{ID,0,0,0, ID,0,0,0, 1,0,0, 2,32'h1000_0000,0,0, 0,1,0,0,0};
    tbl[2]  = '{ID,0,0,0, ID,0,0,0, 1,32'hDEAD_BEEF,0,
                0,0,0,0, 1,1,0,0,32'hDEAD_BEEF};
    tbl[3]  = '{ID,0,0,0, ID,0,0,0, 1,0,0, 0,0,0,0, 1,1,0,0,0};
    tbl[4]  = '{NS,32'h1000_0004,1,0, NS,32'h1000_0008,1,0, 1,0,0,
                0,0,0,0, 1,1,0,0,0};
    tbl[5]  = '{ID,0,0,32'h11, ID,0,0,32'h22, 1,0,0,
                2,32'h1000_0004,1,0, 0,0,0,0,0};
    tbl[6]  = '{ID,0,0,32'h11, ID,0,0,32'h22, 1,0,0,
                2,32'h1000_0008,1,32'h11, 1,0,0,0,0};
    tbl[7]  = '{ID,0,0,32'h11, ID,0,0,32'h22, 1,0,0,
                0,0,0,32'h22, 1,1,0,0,0};
    tbl[8]  = '{ID,0,0,0, NS,32'h2000_0000,0,0, 1,0,0, 0,0,0,0, 1,1,0,0,0};
    tbl[9]  = '{NS,32'h3000_0000,0,0, ID,0,0,0, 1,0,0,
                2,32'h2000_0000,0,0, 1,0,0,0,0};
    tbl[10] = '{ID,0,0,0, ID,0,0,32'h33, 0,0,0,
                2,32'h3000_0000,0,32'h33, 0,0,0,0,0};
    tbl[11] = '{ID,0,0,0, ID,0,0,32'h33, 0,0,0,
                2,32'h3000_0000,0,32'h33, 0,0,0,0,0};
    tbl[12] = '{ID,0,0,0, ID,0,0,32'h33, 0,0,1,
                2,32'h3000_0000,0,32'h33, 0,0,0,1,0};
    tbl[13] = '{ID,0,0,0, ID,0,0,32'h33, 1,0,1,
                2,32'h3000_0000,0,32'h33, 0,1,0,1,0};
    tbl[14] = '{ID,0,0,32'h44, ID,0,0,0, 1,32'h5A5A_5A5A,0,
                0,0,0,32'h44, 1,1,0,0,32'h5A5A_5A5A};
    tbl[15] = '{ID,0,0,0, ID,0,0,0, 1,0,0, 0,0,0,0, 1,1,0,0,0};

    idle_inputs();
    model_reset();
    s_rd = 32'h1234_5678;
    #1;
    chk("rst.HTRANS", s_if.HTRANS, 0);
    chk("rst.HADDR", s_if.HADDR, 0);
    chk("rst.HWDATA", s_if.HWDATA, 0);
    chk("rst.HREADY0", m0_if.HREADY, 1);
    chk("rst.HREADY1", m1_if.HREADY, 1);
    chk("rst.HRESP0", m0_if.HRESP, 0);
    chk("rst.HRESP1", m1_if.HRESP, 0);
    #11 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    for (int i = 0; i < 16; i++) begin
      t_i[0] = tbl[i].t0; a_i[0] = tbl[i].a0;
      w_i[0] = tbl[i].w0; wd_i[0] = tbl[i].wd0;
      t_i[1] = tbl[i].t1; a_i[1] = tbl[i].a1;
      w_i[1] = tbl[i].w1; wd_i[1] = tbl[i].wd1;
      s_rdy = tbl[i].rdy; s_rd = tbl[i].rd; s_rsp = tbl[i].rsp;
      #1;
      chk($sformatf("v%0d.HTRANS", i), s_if.HTRANS, tbl[i].e_tr);
      chk($sformatf("v%0d.HADDR", i), s_if.HADDR, tbl[i].e_ad);
      chk($sformatf("v%0d.HWRITE", i), s_if.HWRITE, tbl[i].e_wr);
      chk($sformatf("v%0d.HWDATA", i), s_if.HWDATA, tbl[i].e_wd);
      chk($sformatf("v%0d.HREADY0", i), m0_if.HREADY, tbl[i].e_r0);
      chk($sformatf("v%0d.HREADY1", i), m1_if.HREADY, tbl[i].e_r1);
      chk($sformatf("v%0d.HRESP0", i), m0_if.HRESP, tbl[i].e_p0);
      chk($sformatf("v%0d.HRESP1", i), m1_if.HRESP, tbl[i].e_p1);
      chk($sformatf("v%0d.HRDATA0", i), m0_if.HRDATA, tbl[i].e_rd0);
      tick();
    end

    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      for (int x = 0; x < 2; x++) begin
        t_i[x]  = 2'($urandom_range(0, 3));
        a_i[x]  = $urandom;
        w_i[x]  = 1'($urandom);
        z_i[x]  = 3'($urandom_range(0, 3));
        wd_i[x] = $urandom;
        sb_i[x] = 4'($urandom);
      end
      s_rdy = ($urandom % 4) != 0;
      s_rsp = ($urandom % 8) == 0;
      s_rd  = $urandom;
      #1;
      check_all();
      tick();
    end

    // drain, then reset in the middle of an M0 data phase
    idle_inputs();
    for (int c = 0; c < 20; c++) begin
      if (!pend[0] && !pend[1] && owner < 0) break;
      tick();
    end
    t_i[0] = NS; a_i[0] = 32'h4000_0000;
    #1 check_all();
    tick();
    t_i[0] = ID;
    #1 check_all();
    tick();
    s_rdy = 1'b0; s_rsp = 1'b1; wd_i[0] = 32'hAAAA_5555;
    #1;
    chk("mid.HRESP0", m0_if.HRESP, 1);
    check_all();
    #1 HRESETn = 1'b0;
    model_reset();
    #1;
    chk("arst.HTRANS", s_if.HTRANS, 0);
    chk("arst.HREADY0", m0_if.HREADY, 1);
    chk("arst.HREADY1", m1_if.HREADY, 1);
    chk("arst.HRESP0", m0_if.HRESP, 0);
    chk("arst.HWDATA", s_if.HWDATA, 0);
    check_all();
    tick();
    #3 HRESETn = 1'b1;
    tick();
    idle_inputs();
    t_i[1] = NS; a_i[1] = 32'h5000_0000;
    #1 check_all();
    tick();
    t_i[1] = ID;
    #1;
    chk("post.HTRANS", s_if.HTRANS, 2);
    chk("post.HADDR", s_if.HADDR, 32'h5000_0000);
    chk("post.HREADY1", m1_if.HREADY, 0);
    tick();
    s_rd = 32'hCAFE_F00D;
    #1;
    chk("post.HREADY1b", m1_if.HREADY, 1);
    chk("post.HRDATA1", m1_if.HRDATA, 32'hCAFE_F00D);
    check_all();
    tick();

`ifdef AHB_ARB_ROUNDROBIN_EN
    idle_inputs();
    cnt[0] = 0; cnt[1] = 0;
    for (int c = 0; c < 60 && grants.size() < 8; c++) begin
      for (int x = 0; x < 2; x++) begin
        if (m_rdy(x) && cnt[x] < 4) begin
          t_i[x] = NS; a_i[x] = 32'(x * 256 + cnt[x]); cnt[x]++;
        end else begin
          t_i[x] = ID;
        end
      end
      #1;
      check_all();
      if (s_if.HTRANS == 2'b10) grants.push_back(int'(s_if.HADDR[8]));
      tick();
    end
    chk("rr.grants", grants.size(), 8);
    for (int i = 1; i < grants.size(); i++)
      chk($sformatf("rr.alt%0d", i), grants[i], 1 - grants[i-1]);
`else
    cnt[0] = 0; cnt[1] = 0;
    if (grants.size() != 0) cnt[0] = 1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
